// File: rtl/or_16.sv
// 16-input OR reduction with a combinational result and a registered result,
// lowest-set-bit index and one-cycle valid strobe.
module or_16 #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic             in_valid,
   output logic             out_comb,
   output logic             out,
   output logic [3:0]       first_idx,
   output logic             out_valid
);

   localparam int unsigned IDX_W = 4;

   logic             any_c;
   logic [IDX_W-1:0] low_idx_c;

   assign any_c    = |a;
   assign out_comb = any_c;

   // Scan from MSB down so the lowest set bit wins; stays 0 for an all-zero word.
   always_comb begin
      low_idx_c = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (a[i]) begin
            low_idx_c = IDX_W'(i);
         end
      end
   end

   // Reset discards any word presented in the same cycle; idle holds the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         out       <= 1'b0;
         first_idx <= '0;
         out_valid <= 1'b0;
      end else if (in_valid) begin
         out       <= any_c;
         first_idx <= low_idx_c;
         out_valid <= 1'b1;
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_or_16.sv
// Self-checking bench for or_16: directed test-plan sequence followed by
// random stimulus, both compared against an arithmetic reference model.
module tb_or_16;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] a;
   logic        in_valid;
   logic        out_comb;
   logic        out;
   logic [3:0]  first_idx;
   logic        out_valid;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Reference model state
   int unsigned m_out   = 0;
   int unsigned m_idx   = 0;
   int unsigned m_valid = 0;

   or_16 dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .in_valid  (in_valid),
      .out_comb  (out_comb),
      .out       (out),
      .first_idx (first_idx),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t a=%h)", tag, obs, exp, $time, a);
      end
   endtask

   function automatic int unsigned ref_any(input int unsigned w);
      return (w != 0) ? 1 : 0;
   endfunction

   // Lowest set bit found by repeated halving; 0 for an all-zero word.
   function automatic int unsigned ref_idx(input int unsigned w);
      int unsigned x = w;
      int unsigned n = 0;
      if (x == 0) return 0;
      while ((x % 2) == 0) begin
         x = x / 2;
         n++;
      end
      return n;
   endfunction

   // Drive one cycle, check the combinational output before the edge and the
   // registered outputs just after it.
   task automatic step(input logic r, input logic v, input logic [15:0] w);
      rst      = r;
      in_valid = v;
      a        = w;
      #1;
      check("out_comb", 32'(out_comb), ref_any(32'(w)));
      @(posedge clk);
      if (r) begin
         m_out = 0; m_idx = 0; m_valid = 0;
      end else if (v) begin
         m_out = ref_any(32'(w)); m_idx = ref_idx(32'(w)); m_valid = 1;
      end else begin
         m_valid = 0;
      end
      #1;
      check("out", 32'(out), m_out);
      check("first_idx", 32'(first_idx), m_idx);
      check("out_valid", 32'(out_valid), m_valid);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      a        = '0;
      @(posedge clk);
      #1;
      step(1'b1, 1'b0, 16'h0000);

      // Directed test plan
      step(1'b0, 1'b1, 16'h0000);
      step(1'b0, 1'b1, 16'h0001);
      step(1'b0, 1'b1, 16'h5555);
      step(1'b0, 1'b1, 16'hAAAA);
      step(1'b0, 1'b1, 16'hFFFF);
      step(1'b0, 1'b1, 16'h8000);
      step(1'b1, 1'b1, 16'h0010);
      step(1'b0, 1'b1, 16'h0100);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000);

      // Single-bit walk covers every index
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'(32'd1 << i));

      // Random traffic with sparse words, idle gaps and occasional reset
      for (int i = 0; i < 400; i++) begin
         logic [15:0] w;
         logic        r;
         logic        v;
         w = 16'($urandom);
         case ($urandom_range(0, 3))
            0: w = '0;
            1: w = w & 16'(~(32'hFFFF >> $urandom_range(0, 15)));
            default: ;
         endcase
         r = ($urandom_range(0, 19) == 0);
         v = ($urandom_range(0, 3) != 0);
         step(r, v, w);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/or_16.md
Name: or_16

Overview:
- 16-input OR reduction unit: asserts its output when any bit of the 16-bit input word is 1.
- Provides an immediate combinational result plus a one-cycle registered result with valid strobe.
- Also reports the index of the lowest set bit.
- Used as a "word nonzero" detector in the datapath, e.g. zero-flag generation and any-request detection.

Parameters:
- WIDTH, 16, input word width; fixed at 16 for this block; implementation must be correct for 16 only.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- a  input  16  data word to reduce
- in_valid  input  1  high when a carries a word to be captured
- out_comb  output  1  combinational OR of all 16 bits of a
- out  output  1  registered OR result of the last captured word
- first_idx  output  4  registered index (0..15) of the lowest set bit of the last captured word
- out_valid  output  1  one-cycle strobe: out/first_idx updated this cycle

Behaviour:
- out_comb = a[0] | a[1] | ... | a[15]
  - Purely combinational, zero latency.
  - Independent of clk, rst and in_valid.
  - Follows a within the same simulation time step.
- Reset (rst high at rising edge of clk):
  - out <= 0, first_idx <= 0, out_valid <= 0.
  - Reset has priority over in_valid.
  - A word presented in the same cycle as reset is discarded.
- Capture (rst low, in_valid high at rising edge):
  - out <= OR-reduction of a.
  - first_idx <= position of least-significant 1 in a; 0 when a == 0.
  - out_valid <= 1.
- Idle (rst low, in_valid low):
  - out and first_idx hold their previous values.
  - out_valid <= 0.
- Latency: 1 clock from capture edge to out/out_valid; throughput 1 word per cycle.
- Back-to-back in_valid:
  - Each cycle's word is captured independently.
  - out_valid stays high continuously.
- Ambiguity rule: first_idx == 0 with out == 0 means "no bit set"; with out == 1 it means bit 0 set.
- Undefined input bits (X/Z) are not required to be handled; a is assumed driven.
- No handshake back-pressure; the block always accepts input.
- No internal state other than out, first_idx, out_valid.

Test Plan:
- a=16'h0000 -> out_comb=0 immediately. With in_valid=1 for one cycle: next cycle out=0, first_idx=0, out_valid=1.
- a=16'h0001 -> out_comb=1. After capture: out=1, first_idx=0, out_valid=1.
- a=16'h5555 -> out_comb=1. After capture: out=1, first_idx=0. Then a=16'hAAAA captured -> out=1, first_idx=1.
- a=16'hFFFF then a=16'h8000, back-to-back in_valid:
  - First result: out=1, first_idx=0; second result: out=1, first_idx=15.
  - out_valid high for both consecutive cycles.
- Reset:
  - After capturing 16'h8000, assert rst with in_valid=1 and a=16'h0010 -> next cycle out=0, first_idx=0, out_valid=0.
  - out_comb remains 1 throughout.
- Hold: capture 16'h0100, then in_valid=0 and a=16'h0000 for 3 cycles:
  - out stays 1, first_idx stays 8, out_valid=0.
  - out_comb=0.
